// File: rtl/frame_stream_scheduler.sv
// Frame sequencer: streams NW x NH raster pixels into the CNN pipeline, forces
// ROW_GAP idle cycles between rows and collects NOUT pipeline results per frame.
// Latency: pixel to pipe_valid/pipe_act is 1 cycle. Backpressure: src_ready
// drops in GAP/FLUSH/DONE/IDLE; the result register has no backpressure and
// flags err_overflow on an overwrite.
//
// Optional feature: define SCHED_PERF_CNT_EN to build the frame latency counter
// behind perf_cycles; otherwise perf_cycles is tied to 0.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, abort        frame control pulses (abort wins over everything)
//   src_valid/src_data/src_ready   pixel source handshake
//   pipe_valid/pipe_act            registered pixel stream to the pipeline
//   pipe_res_vld/pipe_res          single-cycle pipeline result
//   res_valid/res_data/res_ready   handshaked result register
//   busy, frame_done               status (frame_done is a 1-cycle pulse)
//   err_timeout, err_overflow      sticky errors, cleared by start or rst
//   perf_cycles                    cycles from first accepted pixel to DONE
module frame_stream_scheduler #(
   parameter int NW             = 224,
   parameter int NH             = 224,
   parameter int ACT_W          = 48,
   parameter int OUT_W          = 4096,
   parameter int ROW_GAP        = 2,
   parameter int NOUT           = 1,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             src_valid,
   input  logic [ACT_W-1:0] src_data,
   output logic             src_ready,
   output logic             pipe_valid,
   output logic [ACT_W-1:0] pipe_act,
   input  logic             pipe_res_vld,
   input  logic [OUT_W-1:0] pipe_res,
   output logic             res_valid,
   output logic [OUT_W-1:0] res_data,
   input  logic             res_ready,
   output logic             busy,
   output logic             frame_done,
   output logic             err_timeout,
   output logic             err_overflow,
   output logic [31:0]      perf_cycles
);

   // Degenerate sizes would give zero-width counters; keep at least one bit.
   localparam int COL_W = (NW > 1) ? $clog2(NW) : 1;
   localparam int ROW_W = (NH > 1) ? $clog2(NH) : 1;
   localparam int GAP_W = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;
   localparam int OUT_CW = $clog2(NOUT + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam int GAP_LAST_I = (ROW_GAP > 0) ? ROW_GAP - 1 : 0;

   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(NW - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(NH - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_LAST_I);
   localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(NOUT - 1);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_GAP,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [COL_W-1:0]  col_cnt;
   logic [ROW_W-1:0]  row_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [OUT_CW-1:0] out_cnt;
   logic [TO_W-1:0]   to_cnt;

   logic hs;
   logic abort_eff;
   logic start_acc;
   logic timeout_hit;

   // Abort is meaningless in IDLE; everywhere else it wins.
   assign abort_eff  = abort && (state != S_IDLE);
   assign start_acc  = (state == S_IDLE) && start && !abort;
   assign src_ready  = (state == S_STREAM);
   assign hs         = src_valid && (state == S_STREAM);
   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_acc) state_nxt = S_STREAM;
         end
         S_STREAM: begin
            if (hs && (col_cnt == COL_LAST)) begin
               // No trailing gap after the last row of the frame.
               if (row_cnt == ROW_LAST)  state_nxt = S_FLUSH;
               else if (ROW_GAP > 0)     state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = S_STREAM;
         end
         S_FLUSH: begin
            // A completing result on the last timeout cycle still completes.
            if (pipe_res_vld && (out_cnt == OUT_LAST)) begin
               state_nxt = S_DONE;
            end else if (to_cnt == TO_LAST) begin
               state_nxt   = S_IDLE;
               timeout_hit = 1'b1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (abort_eff) begin
         state_nxt   = S_IDLE;
         timeout_hit = 1'b0;
      end
   end

   // Position, gap, result and timeout counters; each clears at terminal count.
   always_ff @(posedge clk) begin
      if (rst || abort_eff) begin
         col_cnt <= '0;
         row_cnt <= '0;
         gap_cnt <= '0;
         out_cnt <= '0;
         to_cnt  <= '0;
      end else begin
         if (hs) begin
            if (col_cnt == COL_LAST) begin
               col_cnt <= '0;
               row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
         end

         if (state == S_GAP) gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
         else                gap_cnt <= '0;

         if (state != S_FLUSH)  out_cnt <= '0;
         else if (pipe_res_vld) out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + 1'b1;

         if (state == S_FLUSH) to_cnt <= (to_cnt == TO_LAST) ? '0 : to_cnt + 1'b1;
         else                  to_cnt <= '0;
      end
   end

   // Pixel path: one register stage; pipe_act holds during bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_valid <= 1'b0;
         pipe_act   <= '0;
      end else begin
         pipe_valid <= hs && !abort_eff;
         if (hs && !abort_eff) pipe_act <= src_data;
      end
   end

   // Result register. Abort leaves it and the error flags untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_data  <= '0;
      end else if (pipe_res_vld) begin
         res_valid <= 1'b1;
         res_data  <= pipe_res;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

   // Error flags: a new error in the same cycle as a start wins over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_timeout  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         if (timeout_hit)    err_timeout <= 1'b1;
         else if (start_acc) err_timeout <= 1'b0;

         if (pipe_res_vld && res_valid && !res_ready) err_overflow <= 1'b1;
         else if (start_acc)                          err_overflow <= 1'b0;
      end
   end

`ifdef SCHED_PERF_CNT_EN
   logic [31:0] perf_cnt;
   logic        perf_run;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cnt    <= '0;
         perf_run    <= 1'b0;
         perf_cycles <= '0;
      end else if (abort_eff) begin
         perf_cnt <= '0;
         perf_run <= 1'b0;
      end else if (state == S_DONE) begin
         perf_cycles <= perf_cnt;
         perf_run    <= 1'b0;
      end else if (hs && !perf_run) begin
         perf_cnt <= '0;
         perf_run <= 1'b1;
      end else if (perf_run && (perf_cnt != 32'hFFFF_FFFF)) begin
         perf_cnt <= perf_cnt + 32'd1;
      end
   end
`else
   assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_frame_stream_scheduler.sv
// Self-checking bench for frame_stream_scheduler.
// Reference model works on beat counts per frame: ready unless the frame is
// complete or a post-row gap is pending; results and errors tracked as events.
module tb_frame_stream_scheduler;
   localparam int NW = 4, NH = 3, ACT_W = 48, OUT_W = 32;
   localparam int ROW_GAP = 2, NOUT = 1, TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, start, abort, src_valid, pipe_res_vld, res_ready;
   logic [ACT_W-1:0] src_data;
   logic [OUT_W-1:0] pipe_res;
   logic             src_ready, pipe_valid, res_valid, busy, frame_done;
   logic             err_timeout, err_overflow;
   logic [ACT_W-1:0] pipe_act;
   logic [OUT_W-1:0] res_data;
   logic [31:0]      perf_cycles;

   frame_stream_scheduler #(
      .NW(NW), .NH(NH), .ACT_W(ACT_W), .OUT_W(OUT_W),
      .ROW_GAP(ROW_GAP), .NOUT(NOUT), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .pipe_valid(pipe_valid), .pipe_act(pipe_act),
      .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .busy(busy), .frame_done(frame_done),
      .err_timeout(err_timeout), .err_overflow(err_overflow),
      .perf_cycles(perf_cycles)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   bit               m_busy = 0, m_done = 0, m_pv = 0, m_rv = 0, m_ovf = 0, m_to = 0;
   int               m_beats = 0, m_gap = 0, m_fl = 0;
   logic [ACT_W-1:0] m_act = '0;
   logic [OUT_W-1:0] m_rd = '0;
   int               pv_cnt = 0;

   // Stimulus controls: vmode 0 idle, 1 always valid, 2 toggle, 3 random
   int vmode = 0;
   bit use_idx = 1;
   bit rnd = 0;

   function automatic bit m_ready();
      return m_busy && !m_done && (m_beats < NW*NH) && (m_gap == 0);
   endfunction

   function automatic bit m_flush();
      return m_busy && !m_done && (m_beats == NW*NH);
   endfunction

   task automatic tick();
      bit rdy, fl, hs, st_ok;
      if (rnd) begin
         res_ready    = 1'($urandom_range(0, 1));
         pipe_res_vld = ($urandom_range(0, 7) == 0);
         pipe_res     = $urandom();
         abort        = m_busy && ($urandom_range(0, 79) == 0);
      end
      case (vmode)
         0:       src_valid = 1'b0;
         1:       src_valid = 1'b1;
         2:       src_valid = ~src_valid;
         default: src_valid = 1'($urandom_range(0, 1));
      endcase
      src_data = use_idx ? ACT_W'(m_beats) : {16'($urandom()), $urandom()};
      rdy = m_ready();
      fl  = m_flush();
      hs  = src_valid && rdy;
      @(posedge clk);
      if (rst) begin
         m_busy = 0; m_done = 0; m_beats = 0; m_gap = 0; m_fl = 0;
         m_pv = 0; m_act = '0; m_rv = 0; m_rd = '0; m_ovf = 0; m_to = 0;
      end else begin
         st_ok = !m_busy && start && !abort;
         if (st_ok) begin m_ovf = 0; m_to = 0; end
         if (pipe_res_vld) begin
            if (m_rv && !res_ready) m_ovf = 1;
            m_rv = 1;
            m_rd = pipe_res;
         end else if (res_ready) begin
            m_rv = 0;
         end
         if (abort && m_busy) begin
            m_busy = 0; m_done = 0; m_beats = 0; m_gap = 0; m_fl = 0; m_pv = 0;
         end else begin
            m_pv = hs;
            if (hs) m_act = src_data;
            if (m_done) begin
               m_done = 0; m_busy = 0;
            end else if (!m_busy) begin
               if (st_ok) begin
                  m_busy = 1; m_beats = 0; m_gap = 0; m_fl = 0; pv_cnt = 0;
               end
            end else if (fl) begin
               if (pipe_res_vld)      m_done = 1;
               else if (m_fl == TO-1) begin m_to = 1; m_busy = 0; end
               else                   m_fl++;
            end else if (hs) begin
               m_beats++;
               if ((m_beats % NW == 0) && (m_beats < NW*NH)) m_gap = ROW_GAP;
            end else if (m_gap > 0) begin
               m_gap--;
            end
         end
      end
      #1;
      chk("src_ready", src_ready, m_ready());
      chk("pipe_valid", pipe_valid, m_pv);
      chk("pipe_act", pipe_act, m_act);
      chk("busy", busy, m_busy);
      chk("frame_done", frame_done, m_done);
      chk("res_valid", res_valid, m_rv);
      chk("res_data", res_data, m_rd);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_timeout", err_timeout, m_to);
      if (pipe_valid) pv_cnt++;
      if (frame_done) chk("frame_beats", pv_cnt, NW*NH);
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse(input logic [OUT_W-1:0] v);
      pipe_res_vld = 1'b1;
      pipe_res     = v;
      tick();
      pipe_res_vld = 1'b0;
   endtask

   task automatic wait_flush();
      int n = 0;
      while (!m_flush() && n < 200) begin tick(); n++; end
      chk("wait_flush_bound", m_flush(), 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_busy && n < 300) begin tick(); n++; end
      chk("wait_idle_bound", m_busy, 0);
   endtask

   task automatic wait_beats(input int b);
      int n = 0;
      while (m_beats < b && n < 200) begin tick(); n++; end
      chk("wait_beats_bound", (m_beats >= b), 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_data = '0;
      pipe_res_vld = 1'b0; pipe_res = '0; res_ready = 1'b0;
      repeat (2) tick();
      chk("perf_rst", perf_cycles, 0);
      chk("pipe_act_rst", pipe_act, 0);
      rst = 1'b0;
      tick();

      // Back-to-back source, beat-index data, result in FLUSH
      vmode = 1;
      start_frame();
      wait_flush();
      repeat (3) tick();
      pulse(32'hABCD);
      chk("res_abcd", res_data, 32'hABCD);
      chk("done_after_res", frame_done, 1);
      wait_idle();
      res_ready = 1'b1; tick(); res_ready = 1'b0;

      // Toggling source valid
      vmode = 2;
      start_frame();
      wait_flush();
      pulse(32'h1234);
      wait_idle();
      vmode = 0;

      // Overflow: two pulses with res_ready low
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      pulse(32'h1111);
      pulse(32'h2222);
      chk("ovf_set", err_overflow, 1);
      chk("ovf_data", res_data, 32'h2222);
      start_frame();
      abort = 1'b1; tick(); abort = 1'b0;
      chk("ovf_cleared", err_overflow, 0);
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      pulse(32'h3333);
      res_ready = 1'b1;
      pulse(32'h4444);
      res_ready = 1'b0;
      chk("no_ovf", err_overflow, 0);
      chk("no_ovf_data", res_data, 32'h4444);
      res_ready = 1'b1; tick(); res_ready = 1'b0;

      // Timeout in FLUSH, then cleared by the next start
      vmode = 3;
      start_frame();
      wait_flush();
      repeat (TO + 2) tick();
      chk("timeout_set", err_timeout, 1);
      chk("timeout_idle", busy, 0);
      start_frame();
      chk("timeout_clr", err_timeout, 0);
      wait_flush();
      pulse(32'h5555);
      wait_idle();

      // Reset mid-frame, then a clean restart from beat 0
      vmode = 1;
      start_frame();
      wait_beats(5);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_pv", pipe_valid, 0);
      chk("rst_act", pipe_act, 0);
      chk("rst_res", res_data, 0);
      start_frame();
      begin
         int n = 0;
         while (!pipe_valid && n < 20) begin tick(); n++; end
      end
      chk("restart_pv", pipe_valid, 1);
      chk("restart_act0", pipe_act, 0);
      wait_flush();
      pulse(32'h6666);
      wait_idle();

      // start mid-frame ignored, frame completes with 12 beats
      start_frame();
      wait_beats(3);
      start_frame();
      wait_flush();
      pulse(32'h7777);
      wait_idle();

      // abort after beat 7
      start_frame();
      wait_beats(7);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_rdy", src_ready, 0);
      repeat (4) tick();

      // Randomized frames: random valid, results, res_ready and aborts
      rnd = 1; use_idx = 0; vmode = 3;
      for (int f = 0; f < 40; f++) begin
         start_frame();
         wait_idle();
         tick();
      end
      rnd = 0; pipe_res_vld = 1'b0; abort = 1'b0; vmode = 0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
